reset_sequencer: RTL and testbench

- Board-level reset controller that replaces free-running power-on reset shifters as the single source of block resets.
- Waits for a stable PLL lock, then releases N_STAGES active-high reset outputs one by one in a fixed order, with a programmable gap between stages.
- Re-asserts all resets on lock loss or on a software reset request.
- Sits at top level between the clock/PLL logic and every downstream datapath block.

---
 rtl/reset_seq_pkg.sv | 26 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/reset_sequencer.sv | 141 ++++++++++++++
 tb/tb_reset_sequencer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared state encodings and default timing for the board reset sequencer.
package reset_seq_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_HOLD    = 3'd0;
   localparam logic [STATE_W-1:0] ST_STABLE  = 3'd1;
   localparam logic [STATE_W-1:0] ST_RELEASE = 3'd2;
   localparam logic [STATE_W-1:0] ST_RUN     = 3'd3;
   localparam logic [STATE_W-1:0] ST_SWRST   = 3'd4;

   typedef enum logic [STATE_W-1:0] {
      HOLD    = ST_HOLD,
      STABLE  = ST_STABLE,
      RELEASE = ST_RELEASE,
      RUN     = ST_RUN,
      SWRST   = ST_SWRST
   } seq_state_e;

   localparam int unsigned DEF_N_STAGES    = 4;
   localparam int unsigned DEF_CNT_W       = 16;
   localparam int unsigned DEF_LOCK_STABLE = 256;
   localparam int unsigned DEF_STAGE_GAP   = 16;
   localparam int unsigned DEF_SW_PULSE    = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level input.
module sync_2ff (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (!reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/reset_sequencer.sv
// Waits for stable PLL lock, then releases stage resets one at a time;
// re-asserts everything on lock loss or software request.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int unsigned N_STAGES    = DEF_N_STAGES,
   parameter int unsigned CNT_W       = DEF_CNT_W,
   parameter int unsigned LOCK_STABLE = DEF_LOCK_STABLE,
   parameter int unsigned STAGE_GAP   = DEF_STAGE_GAP,
   parameter int unsigned SW_PULSE    = DEF_SW_PULSE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                pll_locked,
   input  logic                sw_rst_req,
   input  logic                clr_lock_lost,
   output logic [N_STAGES-1:0] rst_out,
   output logic                seq_done,
   output logic [STATE_W-1:0]  seq_state,
   output logic                lock_lost
);

   localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

   seq_state_e          state, state_d;
   logic [CNT_W-1:0]    cnt, cnt_d;
   logic [IDX_W-1:0]    idx, idx_d;
   logic [N_STAGES-1:0] rst_out_d;
   logic                lock_set;
   logic                lk_s;

   sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (pll_locked),
      .q     (lk_s)
   );

   always_comb begin
      state_d   = state;
      cnt_d     = cnt;
      idx_d     = idx;
      lock_set  = 1'b0;
      rst_out_d = '1;

      case (state)
         HOLD: begin
            cnt_d = '0;
            idx_d = '0;
            if (lk_s && !sw_rst_req) state_d = STABLE;
         end
         STABLE: begin
            if (!lk_s) begin
               state_d = HOLD;
               cnt_d   = '0;
            end else if (sw_rst_req) begin
               state_d = SWRST;
               cnt_d   = '0;
            end else if (cnt == CNT_W'(LOCK_STABLE - 1)) begin
               state_d = RELEASE;
               cnt_d   = '0;
               idx_d   = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         RELEASE: begin
            if (!lk_s) begin
               state_d  = HOLD;
               cnt_d    = '0;
               lock_set = 1'b1;
            end else if (sw_rst_req) begin
               state_d = SWRST;
               cnt_d   = '0;
            end else if (idx == IDX_W'(N_STAGES - 1)) begin
               state_d = RUN;
               cnt_d   = '0;
            end else if (cnt == CNT_W'(STAGE_GAP - 1)) begin
               idx_d = idx + 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!lk_s) begin
               state_d  = HOLD;
               cnt_d    = '0;
               lock_set = 1'b1;
            end else if (sw_rst_req) begin
               state_d = SWRST;
               cnt_d   = '0;
            end
         end
         SWRST: begin
            // Count holds at its terminal value while the request persists
            if (cnt != CNT_W'(SW_PULSE - 1)) begin
               cnt_d = cnt + 1'b1;
            end else if (!sw_rst_req) begin
               state_d = HOLD;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = HOLD;
            cnt_d   = '0;
            idx_d   = '0;
         end
      endcase

      // Outputs are derived from the next state so they register in step with it
      case (state_d)
         RELEASE: begin
            for (int i = 0; i < int'(N_STAGES); i++) rst_out_d[i] = (i > int'(idx_d));
         end
         RUN:     rst_out_d = '0;
         default: rst_out_d = '1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= HOLD;
         cnt       <= '0;
         idx       <= '0;
         rst_out   <= '1;
         seq_done  <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         state     <= state_d;
         cnt       <= cnt_d;
         idx       <= idx_d;
         rst_out   <= rst_out_d;
         seq_done  <= (state_d == RUN);
         lock_lost <= lock_set | (lock_lost & ~clr_lock_lost);
      end
   end

   assign seq_state = STATE_W'(state);

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: directed scenarios plus a random soak
// against a phase/elapsed-time reference model.
module tb_reset_sequencer;

   localparam int N   = 4;
   localparam int LS  = 256;
   localparam int GAP = 16;
   localparam int SWP = 8;

   localparam int P_HOLD = 0, P_STABLE = 1, P_RELEASE = 2, P_RUN = 3, P_SWRST = 4;

   logic       clk = 1'b0;
   logic       reset, pll_locked, sw_rst_req, clr_lock_lost;
   logic [3:0] rst_out;
   logic       seq_done;
   logic [2:0] seq_state;
   logic       lock_lost;

   int total = 0;
   int bad   = 0;

   // Reference model: current phase, cycles spent in it, sticky flag, lock history
   int m_phase, m_age;
   bit m_lost, m_h1, m_h2;

   wire [8:0] obs = {rst_out, seq_done, seq_state, lock_lost};

   reset_sequencer #(
      .N_STAGES(N), .CNT_W(16), .LOCK_STABLE(LS), .STAGE_GAP(GAP), .SW_PULSE(SWP)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .pll_locked    (pll_locked),
      .sw_rst_req    (sw_rst_req),
      .clr_lock_lost (clr_lock_lost),
      .rst_out       (rst_out),
      .seq_done      (seq_done),
      .seq_state     (seq_state),
      .lock_lost     (lock_lost)
   );

   always #5 clk = ~clk;

   function automatic void enter(int p);
      m_phase = p;
      m_age   = 0;
   endfunction

   task automatic model_step();
      bit lk, set;
      if (!reset) begin
         m_phase = P_HOLD; m_age = 0; m_lost = 0; m_h1 = 0; m_h2 = 0;
         return;
      end
      lk   = m_h2;
      m_h2 = m_h1;
      m_h1 = pll_locked;
      set  = 0;
      case (m_phase)
         P_HOLD:  if (lk && !sw_rst_req) enter(P_STABLE);
         P_SWRST: if (m_age >= SWP - 1 && !sw_rst_req) enter(P_HOLD); else m_age++;
         default: begin
            if (!lk) begin
               set = (m_phase != P_STABLE);
               enter(P_HOLD);
            end else if (sw_rst_req) enter(P_SWRST);
            else if (m_phase == P_STABLE && m_age == LS - 1) enter(P_RELEASE);
            else if (m_phase == P_RELEASE && m_age == (N - 1) * GAP) enter(P_RUN);
            else m_age++;
         end
      endcase
      if (set) m_lost = 1;
      else if (clr_lock_lost) m_lost = 0;
   endtask

   // Stage k is free once k*GAP cycles have elapsed since the first release
   function automatic logic [8:0] exp_vec();
      logic [3:0] r;
      r = 4'hF;
      if (m_phase == P_RUN) r = 4'h0;
      else if (m_phase == P_RELEASE)
         for (int k = 0; k < N; k++) r[k] = (m_age < k * GAP);
      return {r, m_phase == P_RUN, 3'(m_phase), m_lost};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic test_reset();
      reset = 0; pll_locked = 1; sw_rst_req = 0; clr_lock_lost = 0;
      for (int c = 0; c < 5; c++) begin
         tick();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL reset c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (obs !== 9'h1E0) begin bad++; $display("FAIL reset_values got=%h exp=1e0", obs); end
      reset = 1;
   endtask

   task automatic test_power_up();
      int c;
      int t[5];
      c = 0;
      for (int k = 0; k < 5; k++) t[k] = -1;
      while (t[4] < 0 && c < 400) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL powerup c=%0d got=%h exp=%h", c, obs, exp_vec()); end
         for (int k = 0; k < N; k++) if (t[k] < 0 && rst_out[k] === 1'b0) t[k] = c;
         if (t[4] < 0 && seq_done === 1'b1) t[4] = c;
      end
      total++; if (t[0] != 2 + 1 + LS) begin bad++; $display("FAIL stage0_time got=%0d exp=%0d", t[0], 2 + 1 + LS); end
      total++;
      if (t[1] - t[0] != GAP || t[2] - t[0] != 2 * GAP || t[3] - t[0] != 3 * GAP) begin
         bad++; $display("FAIL stage_gaps got=%0d,%0d,%0d exp=%0d,%0d,%0d",
                         t[1] - t[0], t[2] - t[0], t[3] - t[0], GAP, 2 * GAP, 3 * GAP);
      end
      total++; if (t[4] != t[3] + 1) begin bad++; $display("FAIL done_time got=%0d exp=%0d", t[4], t[3] + 1); end
   endtask

   task automatic test_glitch();
      int c, at;
      bit saw_hold;
      c = 0; saw_hold = 0;
      at = $urandom_range(150, 50);
      reset = 0; tick(); reset = 1;
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL glitch_rst got=%h exp=%h", obs, exp_vec()); end
      while (!(m_phase == P_STABLE && m_age == at) && c < 300) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL glitch_pre c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      pll_locked = 0; tick(); pll_locked = 1;
      c = 0;
      while (rst_out[0] !== 1'b0 && c < 400) begin
         tick(); c++;
         if (seq_state === 3'd0) saw_hold = 1;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL glitch c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (c != 2 + 1 + LS) begin bad++; $display("FAIL glitch_restart got=%0d exp=%0d", c, 2 + 1 + LS); end
      total++; if (!saw_hold || lock_lost !== 1'b0) begin bad++; $display("FAIL glitch_flag hold=%0d lost=%b exp=1,0", saw_hold, lock_lost); end
   endtask

   task automatic test_lock_loss_run();
      int c;
      c = 0;
      while (m_phase != P_RUN && c < 100) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL ll_seq c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      pll_locked = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL ll_drop i=%0d got=%h exp=%h", i, obs, exp_vec()); end
      end
      total++;
      if ({rst_out, seq_done, lock_lost} !== 6'b111101) begin
         bad++; $display("FAIL ll_outputs got=%b exp=111101", {rst_out, seq_done, lock_lost});
      end
      pll_locked = 1; c = 0;
      while (m_phase != P_RUN && c < 400) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL ll_reseq c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (seq_done !== 1'b1 || lock_lost !== 1'b1) begin bad++; $display("FAIL ll_sticky done=%b lost=%b exp=1,1", seq_done, lock_lost); end
      clr_lock_lost = 1; tick(); clr_lock_lost = 0;
      total++; if (lock_lost !== 1'b0 || obs !== exp_vec()) begin bad++; $display("FAIL ll_clear got=%h exp=%h", obs, exp_vec()); end
   endtask

   task automatic test_sw_reset();
      int c, ones;
      sw_rst_req = 1; tick(); sw_rst_req = 0;
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sw_pulse got=%h exp=%h", obs, exp_vec()); end
      ones = (rst_out === 4'hF) ? 1 : 0;
      c = 0;
      while (rst_out === 4'hF && c < 400) begin
         tick(); c++;
         if (rst_out === 4'hF) ones++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sw_seq c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (ones != SWP + 1 + LS) begin bad++; $display("FAIL sw_hold_len got=%0d exp=%0d", ones, SWP + 1 + LS); end
      c = 0;
      while (m_phase != P_RUN && c < 100) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sw_rel c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
   endtask

   task automatic test_back_to_back();
      int c, ones;
      ones = 0;
      sw_rst_req = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (rst_out === 4'hF && seq_state === 3'd4) ones++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sw_level i=%0d got=%h exp=%h", i, obs, exp_vec()); end
      end
      total++; if (ones != 20) begin bad++; $display("FAIL sw_level_hold got=%0d exp=20", ones); end
      sw_rst_req = 0; c = 0;
      while (m_phase != P_RUN && c < 400) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sw_level_reseq c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (rst_out !== 4'h0 || seq_done !== 1'b1) begin bad++; $display("FAIL sw_level_run got=%h exp=0 done=1", rst_out); end
   endtask

   task automatic test_simultaneous();
      int c;
      reset = 0; tick(); reset = 1;
      c = 0;
      while (!(m_phase == P_RELEASE && m_age == 2 * GAP) && c < 400) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sim_pre c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      // Drop lock early so the synchronised loss meets the request on one edge
      pll_locked = 0; tick(); tick();
      sw_rst_req = 1; clr_lock_lost = 1; tick();
      sw_rst_req = 0; clr_lock_lost = 0; pll_locked = 1;
      total++; if (obs !== exp_vec()) begin bad++; $display("FAIL sim_model got=%h exp=%h", obs, exp_vec()); end
      total++;
      if (seq_state !== 3'd0 || lock_lost !== 1'b1 || rst_out !== 4'hF) begin
         bad++; $display("FAIL sim_priority state=%0d lost=%b rst=%h exp=0,1,f", seq_state, lock_lost, rst_out);
      end
   endtask

   task automatic test_mid_reset();
      int c;
      c = 0;
      while (!(m_phase == P_RELEASE && m_age == GAP) && c < 400) begin
         tick(); c++;
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL mid_pre c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      total++; if (rst_out !== 4'b1100) begin bad++; $display("FAIL mid_idx1 got=%b exp=1100", rst_out); end
      reset = 0; tick(); reset = 1;
      total++; if (obs !== 9'h1E0) begin bad++; $display("FAIL mid_reset got=%h exp=1e0", obs); end
   endtask

   task automatic test_random();
      for (int c = 0; c < 5000; c++) begin
         if (pll_locked) pll_locked = ($urandom_range(599, 0) != 0);
         else pll_locked = ($urandom_range(9, 0) == 0);
         sw_rst_req    = ($urandom_range(499, 0) == 0) ? 1'b1 : (sw_rst_req && $urandom_range(9, 0) != 0);
         clr_lock_lost = ($urandom_range(49, 0) == 0);
         reset         = ($urandom_range(2999, 0) != 0);
         tick();
         total++; if (obs !== exp_vec()) begin bad++; $display("FAIL random c=%0d got=%h exp=%h", c, obs, exp_vec()); end
      end
      reset = 1; sw_rst_req = 0; clr_lock_lost = 0; pll_locked = 1;
   endtask

   initial begin
      reset = 0; pll_locked = 1; sw_rst_req = 0; clr_lock_lost = 0;
      m_phase = P_HOLD; m_age = 0; m_lost = 0; m_h1 = 0; m_h2 = 0;
      test_reset();
      test_power_up();
      test_glitch();
      test_lock_loss_run();
      test_sw_reset();
      test_back_to_back();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
